shift_register_universal: RTL

- Parametrised universal shift register; successor to the fixed 8-bit shift-left/sync-set register family.
- Adds bidirectional shift, parallel load, hold, clock enable, and a shift counter with a word-complete pulse.
- Used as a serialiser/deserialiser front end in the HDL coding-technique example set; maps to slice flip-flops with synchronous control.

---
 rtl/shift_register_universal.sv | 109 ++++++++++
 1 files changed

// File: rtl/shift_register_universal.sv
// Universal shift register: hold, shift left/right, parallel load, clock enable,
// saturating shift counter and a one-cycle word-complete pulse. Optional rotate: SHIFT_REG_ROTATE_EN.
module shift_register_universal #(
   parameter int unsigned           WIDTH   = 8,
   parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
   input  logic                        C,
   input  logic                        R,
   input  logic                        CE,
   input  logic [1:0]                  MODE,
   input  logic                        SIL,
   input  logic                        SIR,
   input  logic [WIDTH-1:0]            D,
`ifdef SHIFT_REG_ROTATE_EN
   input  logic                        ROT,
`endif
   output logic [WIDTH-1:0]            Q,
   output logic                        SOL,
   output logic                        SOR,
   output logic [$clog2(WIDTH+1)-1:0]  CNT,
   output logic                        DONE
);

   localparam int unsigned     CntW   = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

   typedef enum logic [1:0] {
      ModeHold  = 2'b00,
      ModeLeft  = 2'b01,
      ModeRight = 2'b10,
      ModeLoad  = 2'b11
   } mode_e;

   logic [WIDTH-1:0] r_q;
   logic [CntW-1:0]  r_cnt;
   logic             r_done;

   logic [WIDTH-1:0] w_q_d;
   logic [CntW-1:0]  w_cnt_d;
   logic             w_done_d;
   logic [CntW-1:0]  w_cnt_inc;
   logic             w_left_in;
   logic             w_right_in;
   mode_e            w_mode;

   assign w_mode = mode_e'(MODE);

   // Rotation feeds the opposite end back in instead of the serial input.
`ifdef SHIFT_REG_ROTATE_EN
   assign w_left_in  = ROT ? r_q[WIDTH-1] : SIL;
   assign w_right_in = ROT ? r_q[0]       : SIR;
`else
   assign w_left_in  = SIL;
   assign w_right_in = SIR;
`endif

   assign w_cnt_inc = (r_cnt == CntMax) ? r_cnt : r_cnt + CntW'(1);

   always_comb begin
      w_q_d    = r_q;
      w_cnt_d  = r_cnt;
      w_done_d = 1'b0;
      if (CE) begin
         unique case (w_mode)
            ModeHold: begin
               w_q_d   = r_q;
               w_cnt_d = r_cnt;
            end
            ModeLeft: begin
               w_q_d    = {r_q[WIDTH-2:0], w_left_in};
               w_cnt_d  = w_cnt_inc;
               w_done_d = (r_cnt == CntMax - CntW'(1));
            end
            ModeRight: begin
               w_q_d    = {w_right_in, r_q[WIDTH-1:1]};
               w_cnt_d  = w_cnt_inc;
               w_done_d = (r_cnt == CntMax - CntW'(1));
            end
            ModeLoad: begin
               w_q_d   = D;
               w_cnt_d = '0;
            end
            default: begin
               w_q_d   = r_q;
               w_cnt_d = r_cnt;
            end
         endcase
      end
   end

   always_ff @(posedge C) begin
      if (R) begin
         r_q    <= RST_VAL;
         r_cnt  <= '0;
         r_done <= 1'b0;
      end else begin
         r_q    <= w_q_d;
         r_cnt  <= w_cnt_d;
         r_done <= w_done_d;
      end
   end

   assign Q    = r_q;
   assign SOL  = r_q[WIDTH-1];
   assign SOR  = r_q[0];
   assign CNT  = r_cnt;
   assign DONE = r_done;

endmodule
